// File: rtl/pipeline_fifo_pkg.sv
// pipeline_fifo_pkg
//   Shared constants and helpers for the pipeline FIFO.
//   - ptr_w(): pointer width for a given depth
//   - DEQ_PORT / ENQ_PORT / CLR_PORT: EHR port ordering (lower index acts first)
//   - EHR_P: number of EHR ports; 3 when PIPELINE_FIFO_CLEAR_EN is defined, else 2
package pipeline_fifo_pkg;

  localparam int DEQ_PORT = 0;
  localparam int ENQ_PORT = 1;
  localparam int CLR_PORT = 2;

`ifdef PIPELINE_FIFO_CLEAR_EN
  localparam int EHR_P = 3;
`else
  localparam int EHR_P = 2;
`endif

  // Pointer width; a single bit is kept even for degenerate depths.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipeline_fifo_ehr.sv
// pipeline_fifo_ehr
//   Ephemeral history register: one W-bit register with P ordered write ports.
//   Port i observes the value left by ports 0..i-1 in the same cycle; the
//   register captures the result of all ports at posedge clk.
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset (loads RST_VAL)
//   wr_en    per-port write enable
//   wr_data  per-port write value
//   rd       per-port read value (rd[0] is the registered value)
module pipeline_fifo_ehr #(
  parameter int W = 1,
  parameter int P = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [P-1:0]        wr_en,
  input  logic [P-1:0][W-1:0] wr_data,
  output logic [P-1:0][W-1:0] rd
);

  logic [W-1:0] q;
  logic [P:0][W-1:0] chain;

  // Resolve the write ports in order; chain[P] is the next register value.
  always_comb begin
    chain = '0;
    chain[0] = q;
    for (int i = 0; i < P; i++) begin
      if (wr_en[i]) begin
        chain[i+1] = wr_data[i];
      end else begin
        chain[i+1] = chain[i];
      end
    end
  end

  assign rd = chain[P-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else begin
      q <= chain[P];
    end
  end

endmodule

// File: rtl/pipeline_fifo.sv
// pipeline_fifo
//   Pipeline FIFO built from EHR cells. Dequeue (EHR port 0) is ordered before
//   enqueue (port 1), so a full FIFO accepts a new item in the same cycle the
//   head leaves; throughput is one item per cycle at any DEPTH. The only
//   combinational input-to-output paths are deq_ready -> enq_ready and
//   clear -> enq_ready/deq_valid.
//   Optional feature macro: PIPELINE_FIFO_CLEAR_EN adds the clear port, driving
//   EHR port 2 (highest priority) to empty the FIFO; storage is left untouched.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               synchronous flush (PIPELINE_FIFO_CLEAR_EN only)
//   enq_valid/enq_data  producer offer
//   enq_ready           FIFO accepts this cycle
//   deq_valid/deq_data  head item
//   deq_ready           consumer takes head this cycle
module pipeline_fifo
  import pipeline_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
`ifdef PIPELINE_FIFO_CLEAR_EN
  input  logic              clear,
`endif
  input  logic              enq_valid,
  input  logic [DATA_W-1:0] enq_data,
  output logic              enq_ready,
  output logic              deq_valid,
  output logic [DATA_W-1:0] deq_data,
  input  logic              deq_ready
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [DATA_W-1:0] storage [DEPTH];

  logic [EHR_P-1:0]            deq_ptr_we, enq_ptr_we, empty_we, full_we;
  logic [EHR_P-1:0][PTR_W-1:0] deq_ptr_wd, enq_ptr_wd, deq_ptr_rd, enq_ptr_rd;
  logic [EHR_P-1:0][0:0]       empty_wd, full_wd, empty_rd, full_rd;

  logic empty, full, deq_fire, enq_fire, gate_clear;
  logic unused_ok;

  assign empty = empty_rd[DEQ_PORT][0];
  assign full  = full_rd[DEQ_PORT][0];

`ifdef PIPELINE_FIFO_CLEAR_EN
  assign gate_clear = clear;
`else
  assign gate_clear = 1'b0;
`endif

  // Full implies deq_valid, so deq_ready alone guarantees a slot frees up.
  assign deq_valid = !empty && !gate_clear;
  assign enq_ready = !gate_clear && (!full || deq_ready);
  assign deq_data  = storage[deq_ptr_rd[DEQ_PORT]];

  assign deq_fire = deq_valid && deq_ready;
  assign enq_fire = enq_valid && enq_ready;

  // EHR write ports: deq on port 0, enq on port 1 (sees post-deq values), clear on port 2.
  always_comb begin
    deq_ptr_we = '0;
    enq_ptr_we = '0;
    empty_we   = '0;
    full_we    = '0;
    deq_ptr_wd = '0;
    enq_ptr_wd = '0;
    empty_wd   = '0;
    full_wd    = '0;

    deq_ptr_we[DEQ_PORT] = deq_fire;
    deq_ptr_wd[DEQ_PORT] = deq_ptr_rd[DEQ_PORT] + PTR_W'(1);
    full_we[DEQ_PORT]    = deq_fire;
    full_wd[DEQ_PORT]    = 1'b0;
    empty_we[DEQ_PORT]   = deq_fire;
    empty_wd[DEQ_PORT]   = ((deq_ptr_rd[DEQ_PORT] + PTR_W'(1)) == enq_ptr_rd[DEQ_PORT]);

    enq_ptr_we[ENQ_PORT] = enq_fire;
    enq_ptr_wd[ENQ_PORT] = enq_ptr_rd[ENQ_PORT] + PTR_W'(1);
    empty_we[ENQ_PORT]   = enq_fire;
    empty_wd[ENQ_PORT]   = 1'b0;
    full_we[ENQ_PORT]    = enq_fire;
    full_wd[ENQ_PORT]    = ((enq_ptr_rd[ENQ_PORT] + PTR_W'(1)) == deq_ptr_rd[ENQ_PORT]);

`ifdef PIPELINE_FIFO_CLEAR_EN
    deq_ptr_we[CLR_PORT] = clear;
    deq_ptr_wd[CLR_PORT] = '0;
    enq_ptr_we[CLR_PORT] = clear;
    enq_ptr_wd[CLR_PORT] = '0;
    empty_we[CLR_PORT]   = clear;
    empty_wd[CLR_PORT]   = 1'b1;
    full_we[CLR_PORT]    = clear;
    full_wd[CLR_PORT]    = 1'b0;
`endif
  end

  // Payload storage, written only at the registered enq pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
    end else if (enq_fire) begin
      storage[enq_ptr_rd[DEQ_PORT]] <= enq_data;
    end
  end

  pipeline_fifo_ehr #(.W(PTR_W), .P(EHR_P), .RST_VAL('0)) u_deq_ptr (
    .clk(clk), .rst_n(~rst), .wr_en(deq_ptr_we), .wr_data(deq_ptr_wd), .rd(deq_ptr_rd)
  );

  pipeline_fifo_ehr #(.W(PTR_W), .P(EHR_P), .RST_VAL('0)) u_enq_ptr (
    .clk(clk), .rst_n(~rst), .wr_en(enq_ptr_we), .wr_data(enq_ptr_wd), .rd(enq_ptr_rd)
  );

  pipeline_fifo_ehr #(.W(1), .P(EHR_P), .RST_VAL(1'b1)) u_empty (
    .clk(clk), .rst_n(~rst), .wr_en(empty_we), .wr_data(empty_wd), .rd(empty_rd)
  );

  pipeline_fifo_ehr #(.W(1), .P(EHR_P), .RST_VAL(1'b0)) u_full (
    .clk(clk), .rst_n(~rst), .wr_en(full_we), .wr_data(full_wd), .rd(full_rd)
  );

  // Later-port views not needed by the datapath.
  assign unused_ok = ^{empty_rd, full_rd, deq_ptr_rd, enq_ptr_rd};

endmodule

// File: tb/tb_pipeline_fifo.sv
// tb_pipeline_fifo
//   Self-checking bench for pipeline_fifo (DATA_W=8, DEPTH=2). A queue-based
//   reference model predicts deq_valid, deq_data and enq_ready every cycle.
//   Clear tests are included when PIPELINE_FIFO_CLEAR_EN is defined.
module tb_pipeline_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              enq_valid;
  logic [DATA_W-1:0] enq_data;
  logic              enq_ready;
  logic              deq_valid;
  logic [DATA_W-1:0] deq_data;
  logic              deq_ready;
`ifdef PIPELINE_FIFO_CLEAR_EN
  logic              clear;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] model [$];

  pipeline_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
`ifdef PIPELINE_FIFO_CLEAR_EN
    .clear(clear),
`endif
    .enq_valid(enq_valid),
    .enq_data(enq_data),
    .enq_ready(enq_ready),
    .deq_valid(deq_valid),
    .deq_data(deq_data),
    .deq_ready(deq_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check against the model, advance the model.
  task automatic step(input logic ev, input logic [7:0] ed, input logic dr, input logic cl);
    logic exp_valid, exp_ready, df, ef;
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
`ifdef PIPELINE_FIFO_CLEAR_EN
    clear = cl;
`endif
    #1;
    exp_valid = (model.size() > 0) && !cl;
    exp_ready = !cl && ((model.size() < DEPTH) || dr);
    check("deq_valid", {7'b0, deq_valid}, {7'b0, exp_valid});
    check("enq_ready", {7'b0, enq_ready}, {7'b0, exp_ready});
    if (exp_valid) check("deq_data", deq_data, model[0]);
    df = exp_valid && dr;
    ef = ev && exp_ready;
    if (cl) begin
      model.delete();
    end else begin
      if (df) void'(model.pop_front());
      if (ef) model.push_back(ed);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    enq_valid = 1'b0;
    enq_data = 8'h00;
    deq_ready = 1'b0;
`ifdef PIPELINE_FIFO_CLEAR_EN
    clear = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst_deq_valid", {7'b0, deq_valid}, 8'h00);
    check("rst_enq_ready", {7'b0, enq_ready}, 8'h01);
    check("rst_deq_data", deq_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Idle, then a single item with one-cycle latency.
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    check("a5_visible", deq_data, 8'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Fill, then simultaneous deq+enq while full, then drain in order.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b0);
    check("full_kept_head", deq_data, 8'h22);
    drain();

    // Streaming 0..15 with the consumer always ready.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0);
    drain();

    // Empty FIFO with deq_ready and nothing offered.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with one item queued and a handshake offered.
    step(1'b1, 8'h44, 1'b0, 1'b0);
    enq_valid = 1'b1;
    enq_data  = 8'h55;
    deq_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_deq_valid", {7'b0, deq_valid}, 8'h00);
    check("midrst_enq_ready", {7'b0, enq_ready}, 8'h01);
    check("midrst_deq_data", deq_data, 8'h00);
    model.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h7E, 1'b0, 1'b0);
    check("post_rst_7e", deq_data, 8'h7E);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef PIPELINE_FIFO_CLEAR_EN
    // Clear while full with an enq offered.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b1);
    step(1'b1, 8'h5C, 1'b0, 1'b0);
    check("post_clear_5c", deq_data, 8'h5C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic cl;
`ifdef PIPELINE_FIFO_CLEAR_EN
      cl = ($urandom_range(0, 19) == 0);
`else
      cl = 1'b0;
`endif
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0), cl);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
